// File: rtl/led_scan_sched.sv
// RGB LED matrix scan scheduler: double-buffered PWM duties, round-robin write port,
// frame-synchronous commit of the shadow buffer into the displayed buffer.
module led_scan_sched #(
    parameter int unsigned NUM_LEDS = 11,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_a_valid,
    output logic                req_a_ready,
    input  logic [3:0]          req_a_led,
    input  logic [1:0]          req_a_chan,
    input  logic [7:0]          req_a_value,
    input  logic                req_b_valid,
    output logic                req_b_ready,
    input  logic [3:0]          req_b_led,
    input  logic [1:0]          req_b_chan,
    input  logic [7:0]          req_b_value,
    input  logic                commit_req,
    output logic                commit_pending,
    output logic                frame_start,
    output logic                addr_err,
    output logic [NUM_LEDS-1:0] ledc,
    output logic [2:0]          ledrgb
);
    localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [4:0]  LED_LIM = 5'(NUM_LEDS);

    logic [PW-1:0] presc;
    logic [7:0]    step;
    logic [1:0]    phase;
    logic          tick;
    logic          boundary;
    logic          commit_now;
    logic          rr;
    logic          started;
    logic          fs_arm;
    logic          wr_a;
    logic          wr_b;
    logic          wr_en;
    logic          wr_ok;
    logic [3:0]    wr_led;
    logic [1:0]    wr_chan;
    logic [7:0]    wr_value;

    logic [7:0] shadow [NUM_LEDS][3];
    logic [7:0] active [NUM_LEDS][3];

    assign tick       = (presc == PRE_MAX);
    assign boundary   = tick && (phase == 2'd2) && (step == 8'hFF);
    assign commit_now = boundary && (commit_pending || commit_req);

    // rr=0 favours A; both ports are blocked on the commit edge
    assign req_a_ready = !commit_now && (!req_b_valid || !rr);
    assign req_b_ready = !commit_now && (!req_a_valid || rr);
    assign wr_a  = req_a_valid && req_a_ready;
    assign wr_b  = req_b_valid && req_b_ready;
    assign wr_en = wr_a || wr_b;

    always_comb begin
        wr_led   = req_a_led;
        wr_chan  = req_a_chan;
        wr_value = req_a_value;
        if (wr_b) begin
            wr_led   = req_b_led;
            wr_chan  = req_b_chan;
            wr_value = req_b_value;
        end
    end

    assign wr_ok = ({1'b0, wr_led} < LED_LIM) && (wr_chan != 2'd3);

    // prescaler / step / phase scan counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            step  <= '0;
            phase <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                step <= step + 8'd1;
                if (step == 8'hFF)
                    phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            end
        end
    end

    // arbitration pointer, commit and error flags, frame marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr             <= 1'b0;
            commit_pending <= 1'b0;
            addr_err       <= 1'b0;
            started        <= 1'b0;
            fs_arm         <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            if (wr_a)
                rr <= 1'b1;
            else if (wr_b)
                rr <= 1'b0;
            if (commit_now)
                commit_pending <= 1'b0;
            else if (commit_req)
                commit_pending <= 1'b1;
            if (wr_en && !wr_ok)
                addr_err <= 1'b1;
            started     <= 1'b1;
            fs_arm      <= !started || boundary;
            frame_start <= fs_arm;
        end
    end

    // shadow writes and whole-buffer commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < int'(NUM_LEDS); l++) begin
                for (int c = 0; c < 3; c++) begin
                    shadow[l][c] <= 8'h00;
                    active[l][c] <= 8'h00;
                end
            end
        end else begin
            if (wr_en && wr_ok)
                shadow[wr_led][wr_chan] <= wr_value;
            if (commit_now) begin
                for (int l = 0; l < int'(NUM_LEDS); l++) begin
                    for (int c = 0; c < 3; c++)
                        active[l][c] <= shadow[l][c];
                end
            end
        end
    end

    // PWM compare against the displayed buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ledrgb <= 3'b000;
            ledc   <= '0;
        end else begin
            ledrgb <= 3'b001 << phase;
            for (int l = 0; l < int'(NUM_LEDS); l++)
                ledc[l] <= (step < active[l][phase]);
        end
    end

endmodule

// File: tb/tb_led_scan_sched.sv
// Bench for led_scan_sched: frame-position model checked every cycle plus directed scenarios.
module tb_led_scan_sched;
    localparam int NL    = 11;
    localparam int FRAME = 768;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [3:0]    a_led, b_led;
    logic [1:0]    a_chan, b_chan;
    logic [7:0]    a_value, b_value;
    logic          commit_req, commit_pending, frame_start, addr_err;
    logic [NL-1:0] ledc;
    logic [2:0]    ledrgb;

    always #5 clk = ~clk;

    led_scan_sched #(.NUM_LEDS(NL), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst),
        .req_a_valid(a_valid), .req_a_ready(a_ready), .req_a_led(a_led),
        .req_a_chan(a_chan), .req_a_value(a_value),
        .req_b_valid(b_valid), .req_b_ready(b_ready), .req_b_led(b_led),
        .req_b_chan(b_chan), .req_b_value(b_value),
        .commit_req(commit_req), .commit_pending(commit_pending),
        .frame_start(frame_start), .addr_err(addr_err),
        .ledc(ledc), .ledrgb(ledrgb)
    );

    int vec = 0;
    int miscmp = 0;

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // model: frame position = edges since reset, buffers as plain arrays
    int            sh  [NL][3];
    int            act [NL][3];
    int            cnt;
    bit            pend, aerr, last_b;
    int            pos, ph, st, wl, wc, wv, bad;
    bit            blk, ga, gb, e_fs;
    logic [NL-1:0] e_ledc;
    logic [2:0]    e_rgb;

    always @(negedge clk) begin
        if (rst) begin
            for (int l = 0; l < NL; l++)
                for (int c = 0; c < 3; c++) begin
                    sh[l][c]  = 0;
                    act[l][c] = 0;
                end
            cnt = 0; pend = 0; aerr = 0; last_b = 1;
            chk("rst_ledc", int'(ledc), 0);
            chk("rst_ledrgb", int'(ledrgb), 0);
            chk("rst_frame_start", int'(frame_start), 0);
            chk("rst_commit_pending", int'(commit_pending), 0);
        end else begin
            pos = cnt % FRAME;
            ph  = pos / 256;
            st  = pos % 256;
            blk = (pos == FRAME - 1) && (pend || commit_req);
            ga  = !blk && a_valid && (!b_valid || last_b);
            gb  = !blk && b_valid && (!a_valid || !last_b);
            if (a_valid || blk) chk("ready_a", int'(a_ready), int'(ga));
            if (b_valid || blk) chk("ready_b", int'(b_ready), int'(gb));
            e_rgb = 3'(1 << ph);
            for (int l = 0; l < NL; l++) e_ledc[l] = (st < act[l][ph]);
            e_fs = (cnt == 1) || (cnt >= FRAME && cnt % FRAME == 0);
            if (ga || gb) begin
                wl = ga ? int'(a_led)   : int'(b_led);
                wc = ga ? int'(a_chan)  : int'(b_chan);
                wv = ga ? int'(a_value) : int'(b_value);
                if (wl < NL && wc != 3) sh[wl][wc] = wv;
                else aerr = 1;
                last_b = gb;
            end
            if (blk) begin
                act  = sh;
                pend = 0;
            end else if (commit_req) pend = 1;
            cnt++;
            @(posedge clk);
            #1;
            chk("ledc", int'(ledc), int'(e_ledc));
            chk("ledrgb", int'(ledrgb), int'(e_rgb));
            chk("frame_start", int'(frame_start), int'(e_fs));
            chk("commit_pending", int'(commit_pending), int'(pend));
            chk("addr_err", int'(addr_err), int'(aerr));
            bad = 0;
            for (int l = 0; l < NL; l++)
                for (int c = 0; c < 3; c++)
                    if (int'(dut.shadow[l][c]) != sh[l][c]) bad++;
            chk("shadow_entries_wrong", bad, 0);
            bad = 0;
            for (int l = 0; l < NL; l++)
                for (int c = 0; c < 3; c++)
                    if (int'(dut.active[l][c]) != act[l][c]) bad++;
            chk("active_entries_wrong", bad, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write_a(input int led, input int chan, input int val);
        a_valid = 1; a_led = 4'(led); a_chan = 2'(chan); a_value = 8'(val);
        step();
        a_valid = 0;
    endtask

    task automatic commit_pulse();
        commit_req = 1;
        step();
        commit_req = 0;
        chk("commit_pending_set", int'(commit_pending), 1);
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        do begin
            step();
            n++;
        end while (cnt % FRAME != target && n < 2000);
        chk("wait_pos", cnt % FRAME, target);
    endtask

    task automatic count_frame(input int led, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (FRAME) begin
            step();
            if (ledc[led]) begin
                case (ledrgb)
                    3'b001:  c0++;
                    3'b010:  c1++;
                    3'b100:  c2++;
                    default: c2 += 1000;
                endcase
            end
        end
    endtask

    logic [3:0] a_order;
    int         n0, n1, n2, nz;

    initial begin
        a_valid = 0; b_valid = 0; commit_req = 0;
        a_led = 0; a_chan = 0; a_value = 0;
        b_led = 0; b_chan = 0; b_value = 0;
        #1 rst = 1;
        #1 chk("rst_ledrgb_async", int'(ledrgb), 0);
        repeat (2) @(posedge clk);
        #2 rst = 0;
        step(); chk("ledrgb_first_edge", int'(ledrgb), 1);
        chk("frame_start_edge1", int'(frame_start), 0);
        step(); chk("frame_start_edge2", int'(frame_start), 1);
        step(); chk("frame_start_edge3", int'(frame_start), 0);

        // both requesters valid: grants must alternate A,B,A,B
        a_order = 4'b0101;
        a_valid = 1; b_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_led = 4'(2 + i); a_chan = 2'd0; a_value = 8'(8'h10 + i);
            b_led = 4'(6 + i); b_chan = 2'd1; b_value = 8'(8'h20 + i);
            #1;
            chk("rr_grant_a", int'(a_ready), int'(a_order[i]));
            chk("rr_grant_b", int'(b_ready), int'(!a_order[i]));
            step();
        end
        a_valid = 0; b_valid = 0;
        chk("rr_shadow_a0", int'(dut.shadow[2][0]), 8'h10);
        chk("rr_shadow_b1", int'(dut.shadow[7][1]), 8'h21);
        chk("rr_shadow_a2", int'(dut.shadow[4][0]), 8'h12);
        chk("rr_shadow_b3", int'(dut.shadow[9][1]), 8'h23);
        chk("rr_shadow_skipped", int'(dut.shadow[3][0]), 0);

        // duty 0x80 in phase 0 of led 0
        write_a(0, 0, 8'h80);
        commit_pulse();
        wait_pos(0);
        chk("commit_cleared", int'(commit_pending), 0);
        count_frame(0, n0, n1, n2);
        chk("duty80_phase0", n0, 128);
        chk("duty80_phase1", n1, 0);
        chk("duty80_phase2", n2, 0);

        // duty 0x00 and 0xFF on led 1
        write_a(1, 0, 8'h00);
        write_a(1, 1, 8'hFF);
        commit_pulse();
        wait_pos(0);
        count_frame(1, n0, n1, n2);
        chk("duty00_phase0", n0, 0);
        chk("dutyFF_phase1", n1, 255);
        chk("duty_phase2", n2, 0);

        // out-of-range writes complete but are dropped
        a_valid = 1; a_led = 4'd11; a_chan = 2'd0; a_value = 8'h55;
        #1 chk("oob_led_ready", int'(a_ready), 1);
        step(); a_valid = 0;
        chk("oob_led_err", int'(addr_err), 1);
        b_valid = 1; b_led = 4'd0; b_chan = 2'd3; b_value = 8'h66;
        #1 chk("oob_chan_ready", int'(b_ready), 1);
        step(); b_valid = 0;
        repeat (3) step();
        chk("addr_err_sticky", int'(addr_err), 1);
        chk("oob_shadow_kept", int'(dut.shadow[0][0]), 8'h80);

        // mid-frame commit with a write colliding with the boundary
        wait_pos(300);
        write_a(5, 2, 8'h77);
        commit_pulse();
        wait_pos(FRAME - 1);
        a_valid = 1; a_led = 4'd3; a_chan = 2'd2; a_value = 8'h42;
        #1 chk("ready_on_boundary", int'(a_ready), 0);
        step();
        chk("boundary_commit_done", int'(commit_pending), 0);
        chk("boundary_copy", int'(dut.active[5][2]), 8'h77);
        chk("ready_after_boundary", int'(a_ready), 1);
        step(); a_valid = 0;
        chk("late_write_shadow", int'(dut.shadow[3][2]), 8'h42);
        chk("late_write_not_active", int'(dut.active[3][2]), 0);

        // reset with a commit pending mid-frame
        write_a(6, 0, 8'h99);
        commit_pulse();
        rst = 1;
        #1;
        chk("rst_mid_ledc", int'(ledc), 0);
        chk("rst_mid_ledrgb", int'(ledrgb), 0);
        chk("rst_mid_pending", int'(commit_pending), 0);
        chk("rst_mid_addr_err", int'(addr_err), 0);
        nz = 0;
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < 3; c++)
                if (dut.active[l][c] != 8'h00 || dut.shadow[l][c] != 8'h00) nz++;
        chk("rst_mid_buffers_zero", nz, 0);
        step();
        rst = 0;
        step(); chk("rerun_ledrgb", int'(ledrgb), 1);
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
